// File: rtl/dda_axis_stepper.sv
// Per-axis DDA step generator: latches per-slot increment/acceleration/direction on load,
// accumulates phase on each DDA tick, and emits fixed-width step pulses with position tracking.
module dda_axis_stepper #(
    parameter int buffer_bits  = 2,
    parameter int buffer_size  = 4,
    parameter int inc_bits     = 32,
    parameter int pos_bits     = 32,
    parameter int pulse_cycles = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            dda_tick,
    input  logic                            loading_move,
    input  logic                            executing_move,
    input  logic [buffer_bits-1:0]          moveind,
    input  logic [buffer_size*inc_bits-1:0] increment,
    input  logic [buffer_size*inc_bits-1:0] incrementincrement,
    input  logic [buffer_size-1:0]          direction,
    output logic                            step,
    output logic                            dir,
    output logic [pos_bits-1:0]             position,
    output logic                            step_overrun
);

    localparam int cnt_bits = $clog2(pulse_cycles + 1);
    localparam logic [cnt_bits-1:0] pulse_load = cnt_bits'(pulse_cycles);
    localparam logic [cnt_bits-1:0] cnt_one    = cnt_bits'(1);
    localparam logic [pos_bits-1:0] pos_one    = pos_bits'(1);

    logic [1:0]            tick_hist_q, tick_hist_d;
    logic [inc_bits-1:0]   acc_q, acc_d;
    logic [inc_bits-1:0]   inc_q, inc_d;
    logic [inc_bits-1:0]   accel_q, accel_d;
    logic                  dir_q, dir_d;
    logic [pos_bits-1:0]   pos_q, pos_d;
    logic [cnt_bits-1:0]   cnt_q, cnt_d;
    logic                  step_q, step_d;
    logic                  overrun_q, overrun_d;

    logic                  tick_edge_s;
    logic                  step_evt_s;
    logic [inc_bits:0]     sum_s;
    logic [inc_bits+1:0]   inc_next_s;
    int                    slot_base_s;

    // Next-state logic: load latching, tick-driven phase/rate update, position and pulse timing
    always_comb begin
        tick_hist_d = {tick_hist_q[0], dda_tick};
        tick_edge_s = (tick_hist_q == 2'b01);
        slot_base_s = int'(moveind) * inc_bits;
        sum_s       = {1'b0, acc_q} + {1'b0, inc_q};
        // Rate update is a signed add of unsigned rate and signed accel, two guard bits wide
        inc_next_s  = $signed({2'b00, inc_q}) + $signed({{2{accel_q[inc_bits-1]}}, accel_q});

        acc_d       = acc_q;
        inc_d       = inc_q;
        accel_d     = accel_q;
        dir_d       = dir_q;
        pos_d       = pos_q;
        cnt_d       = cnt_q;
        overrun_d   = overrun_q;
        step_evt_s  = 1'b0;

        if (loading_move) begin
            inc_d   = increment[slot_base_s +: inc_bits];
            accel_d = incrementincrement[slot_base_s +: inc_bits];
            dir_d   = direction[moveind];
        end else if (tick_edge_s && executing_move && enable) begin
            acc_d      = sum_s[inc_bits-1:0];
            step_evt_s = sum_s[inc_bits];
            if (inc_next_s[inc_bits+1]) begin
                inc_d = {inc_bits{1'b0}};
            end else if (inc_next_s[inc_bits]) begin
                inc_d = {inc_bits{1'b1}};
            end else begin
                inc_d = inc_next_s[inc_bits-1:0];
            end
        end else begin
            acc_d = acc_q;
        end

        if (step_evt_s) begin
            if (dir_q) begin
                pos_d = pos_q + pos_one;
            end else begin
                pos_d = pos_q - pos_one;
            end
            if (cnt_q != {cnt_bits{1'b0}}) begin
                overrun_d = 1'b1;
            end else begin
                overrun_d = overrun_q;
            end
            cnt_d = pulse_load;
        end else if (!enable) begin
            cnt_d = {cnt_bits{1'b0}};
        end else if (cnt_q != {cnt_bits{1'b0}}) begin
            cnt_d = cnt_q - cnt_one;
        end else begin
            cnt_d = cnt_q;
        end

        step_d = (cnt_d != {cnt_bits{1'b0}});
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_hist_q <= 2'b00;
            acc_q       <= {inc_bits{1'b0}};
            inc_q       <= {inc_bits{1'b0}};
            accel_q     <= {inc_bits{1'b0}};
            dir_q       <= 1'b0;
            pos_q       <= {pos_bits{1'b0}};
            cnt_q       <= {cnt_bits{1'b0}};
            step_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            tick_hist_q <= tick_hist_d;
            acc_q       <= acc_d;
            inc_q       <= inc_d;
            accel_q     <= accel_d;
            dir_q       <= dir_d;
            pos_q       <= pos_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            overrun_q   <= overrun_d;
        end
    end

    assign step         = step_q;
    assign dir          = dir_q;
    assign position     = pos_q;
    assign step_overrun = overrun_q;

endmodule

// File: tb/tb_dda_axis_stepper.sv
// Randomized and directed bench for dda_axis_stepper, checked every cycle against an
// arithmetic reference model; a second 8-bit-position instance exercises signed wrap.
module tb_dda_axis_stepper;

    localparam int P = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic          dda_tick = 1'b0;
    logic          loading_move = 1'b0;
    logic          executing_move = 1'b0;
    logic [1:0]    moveind = 2'd0;
    logic [127:0]  inc_vec = 128'd0;
    logic [127:0]  acc_vec = 128'd0;
    logic [3:0]    dir_vec = 4'd0;

    logic          step, dir, step_overrun;
    logic [31:0]   position;
    logic          step_n, dir_n, step_overrun_n;
    logic [7:0]    position_n;

    int total = 0;
    int bad = 0;

    dda_axis_stepper #(.buffer_bits(2), .buffer_size(4), .inc_bits(32), .pos_bits(32), .pulse_cycles(P)) dut (
        .clk(clk), .reset(reset), .enable(enable), .dda_tick(dda_tick),
        .loading_move(loading_move), .executing_move(executing_move), .moveind(moveind),
        .increment(inc_vec), .incrementincrement(acc_vec), .direction(dir_vec),
        .step(step), .dir(dir), .position(position), .step_overrun(step_overrun)
    );

    dda_axis_stepper #(.buffer_bits(2), .buffer_size(4), .inc_bits(32), .pos_bits(8), .pulse_cycles(P)) dut_n (
        .clk(clk), .reset(reset), .enable(enable), .dda_tick(dda_tick),
        .loading_move(loading_move), .executing_move(executing_move), .moveind(moveind),
        .increment(inc_vec), .incrementincrement(acc_vec), .direction(dir_vec),
        .step(step_n), .dir(dir_n), .position(position_n), .step_overrun(step_overrun_n)
    );

    always #5 clk = ~clk;

    // Reference model state
    longint       m_acc, m_inc, m_accel;
    bit           m_dir, m_step, m_ovr, m_alive;
    logic [31:0]  m_pos;
    bit           s1, s2;
    int           cyc = 0;
    int           last_evt = 0;
    bit           chk_on = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit tedge, evt;
        longint sum, n;
        cyc++;
        if (reset) begin
            m_acc = 0; m_inc = 0; m_accel = 0; m_dir = 0; m_step = 0; m_ovr = 0;
            m_alive = 0; m_pos = 32'd0; s1 = 0; s2 = 0;
        end else begin
            tedge = (!s2 && s1);
            s2 = s1;
            s1 = dda_tick;
            evt = 0;
            if (loading_move) begin
                m_inc   = longint'(inc_vec[moveind*32 +: 32]);
                m_accel = longint'($signed(acc_vec[moveind*32 +: 32]));
                m_dir   = dir_vec[moveind];
            end else if (tedge && executing_move && enable) begin
                sum   = m_acc + m_inc;
                evt   = (sum >= 64'sh1_0000_0000);
                m_acc = sum % 64'sh1_0000_0000;
                n     = m_inc + m_accel;
                if (n < 0) m_inc = 0;
                else if (n > 64'sh0_FFFF_FFFF) m_inc = 64'sh0_FFFF_FFFF;
                else m_inc = n;
            end
            if (evt) begin
                if (m_step) m_ovr = 1;
                m_pos    = m_dir ? m_pos + 32'd1 : m_pos - 32'd1;
                m_alive  = 1;
                last_evt = cyc;
            end else if (!enable) begin
                m_alive = 0;
            end
            m_step = m_alive && ((cyc - last_evt) < P);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_edge();
    end

    // Per-cycle comparison plus pulse-shape monitors for the directed checks
    int  hi_cnt = 0;
    int  gap_cnt = 0;
    bit  win = 0;
    bit  seen_hi = 0;
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("step", {31'd0, step}, {31'd0, m_step});
            chk("dir", {31'd0, dir}, {31'd0, m_dir});
            chk("position", position, m_pos);
            chk("overrun", {31'd0, step_overrun}, {31'd0, m_ovr});
            chk("position8", {24'd0, position_n}, {24'd0, m_pos[7:0]});
        end
        if (step) hi_cnt++;
        if (win && seen_hi && !step) gap_cnt++;
        if (win && step) seen_hi = 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick(input int h);
        dda_tick = 1'b1;
        step_clk(h);
        dda_tick = 1'b0;
        step_clk(h);
    endtask

    task automatic set_slot(input int k, input logic [31:0] inc, input logic [31:0] acc, input logic d);
        inc_vec[k*32 +: 32] = inc;
        acc_vec[k*32 +: 32] = acc;
        dir_vec[k] = d;
    endtask

    task automatic load(input int k);
        loading_move   = 1'b1;
        executing_move = 1'b0;
        moveind        = 2'(k);
        step_clk(1);
        loading_move   = 1'b0;
        executing_move = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step_clk(2);
        reset = 1'b0;
    endtask

    initial begin
        int guard;
        logic [31:0] saved;
        logic [31:0] r32;
        step_clk(3);
        chk_on = 1;
        reset  = 1'b0;
        @(negedge clk);
        chk("reset_pos", position, 32'd0);
        chk("reset_step", {31'd0, step}, 32'd0);

        // 1: half-rate increment, slow ticks
        set_slot(0, 32'h8000_0000, 32'd0, 1'b1);
        load(0);
        hi_cnt = 0;
        for (int i = 0; i < 10; i++) tick(32);
        step_clk(16);
        @(negedge clk);
        chk("t1_pos", position, 32'd5);
        chk("t1_ovr", {31'd0, step_overrun}, 32'd0);
        chk("t1_hi_cycles", hi_cnt, 32'd40);

        // 2: quarter rate, negative direction
        set_slot(2, 32'h4000_0000, 32'd0, 1'b0);
        load(2);
        @(negedge clk);
        chk("t2_dir", {31'd0, dir}, 32'd0);
        for (int i = 0; i < 8; i++) tick(4);
        step_clk(12);
        @(negedge clk);
        chk("t2_pos", position, 32'd3);

        // 3: acceleration ramp up then clamped deceleration
        set_slot(1, 32'd0, 32'h1000_0000, 1'b1);
        load(1);
        for (int i = 0; i < 16; i++) tick(4);
        set_slot(3, 32'hF000_0000, 32'hE000_0000, 1'b1);
        load(3);
        for (int i = 0; i < 12; i++) tick(4);
        saved = m_pos;
        for (int i = 0; i < 8; i++) tick(4);
        step_clk(10);
        @(negedge clk);
        chk("t3_stopped", position, saved);

        // 4: max rate with fast ticks overruns the pulse
        do_reset();
        set_slot(0, 32'hFFFF_FFFF, 32'd0, 1'b1);
        load(0);
        win = 1; seen_hi = 0; gap_cnt = 0;
        for (int i = 0; i < 6; i++) tick(2);
        win = 0;
        step_clk(10);
        @(negedge clk);
        chk("t4_ovr", {31'd0, step_overrun}, 32'd1);
        chk("t4_pos", position, 32'd5);
        chk("t4_gap", gap_cnt, 32'd0);
        chk("t4_seen", {31'd0, seen_hi}, 32'd1);

        // 5: enable drop mid-pulse freezes phase
        do_reset();
        set_slot(0, 32'h8000_0000, 32'd0, 1'b1);
        load(0);
        tick(4);
        tick(4);
        enable = 1'b0;
        step_clk(1);
        @(negedge clk);
        chk("t5_step_low", {31'd0, step}, 32'd0);
        for (int i = 0; i < 10; i++) tick(4);
        @(negedge clk);
        chk("t5_frozen", position, 32'd1);
        enable = 1'b1;
        step_clk(1);
        tick(4);
        tick(4);
        @(negedge clk);
        chk("t5_resume", position, 32'd2);

        // 6: signed wrap on the 8-bit instance, then reset mid-pulse
        do_reset();
        set_slot(0, 32'hFFFF_FFFF, 32'd0, 1'b1);
        load(0);
        guard = 0;
        while (m_pos != 32'd127 && guard < 400) begin
            tick(1);
            guard++;
        end
        chk("t6_guard", {31'd0, (guard < 400)}, 32'd1);
        @(negedge clk);
        chk("t6_pos8_7f", {24'd0, position_n}, 32'h7F);
        tick(1);
        @(negedge clk);
        chk("t6_pos8_80", {24'd0, position_n}, 32'h80);
        chk("t6_pos_wide", position, 32'h80);
        tick(1);
        step_clk(2);
        reset = 1'b1;
        step_clk(1);
        @(negedge clk);
        chk("t6_rst_step", {31'd0, step}, 32'd0);
        chk("t6_rst_pos", position, 32'd0);
        chk("t6_rst_dir", {31'd0, dir}, 32'd0);
        chk("t6_rst_ovr", {31'd0, step_overrun}, 32'd0);
        chk("t6_rst_pos8", {24'd0, position_n}, 32'd0);
        reset = 1'b0;
        step_clk(1);

        // 7: randomized loads, ticks, enable and execute toggling
        for (int it = 0; it < 500; it++) begin
            case ($urandom_range(0, 9))
                0, 1: begin
                    case ($urandom_range(0, 3))
                        0: r32 = $urandom;
                        1: r32 = $urandom >> 4;
                        2: r32 = 32'd0;
                        default: r32 = 32'hFFFF_FFFF;
                    endcase
                    set_slot($urandom_range(0, 3), r32,
                             ($urandom_range(0, 1) == 1) ? ($urandom >> 6) : (32'd0 - ($urandom >> 6)),
                             1'($urandom_range(0, 1)));
                    load($urandom_range(0, 3));
                end
                2: enable = ($urandom_range(0, 3) != 0);
                3: executing_move = ($urandom_range(0, 7) != 0);
                default: tick($urandom_range(1, 5));
            endcase
        end
        step_clk(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
